// File: rtl/otter_arb_pkg.sv
// Shared types and defaults for the OTTER instruction/data memory arbiter.
package otter_arb_pkg;

  localparam int MAX_WAIT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    RESP_I,
    RESP_D
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/otter_arb_starve_ctr.sv
// Saturating count of data grants taken while a fetch is kept waiting.
module otter_arb_starve_ctr #(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CNT_W = ($clog2(MAX_WAIT + 1) < 2) ? 2 : $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  assign at_max = (wait_cnt_q == CNT_W'(MAX_WAIT));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr) begin
      wait_cnt_d = '0;
    end else if (inc && !at_max) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Single-port memory arbiter: data has priority, fetch is forced through after
// MAX_WAIT consecutive data wins; responses come back one cycle after grant.
module otter_mem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int ADDR_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic              I_GNT,
  output logic              I_VALID,
  output logic [31:0]       I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [31:0]       D_WDATA,
  input  logic [1:0]        D_SIZE,
  input  logic              D_SIGN,
  output logic              D_GNT,
  output logic              D_VALID,
  output logic [31:0]       D_RDATA,
  output logic              M_RE,
  output logic              M_WE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [31:0]       M_WDATA,
  output logic [1:0]        M_SIZE,
  output logic              M_SIGN,
  input  logic [31:0]       M_RDATA
);

  state_e state_q, state_d;
  owner_e owner;
  logic   wr_q, wr_d;
  logic   at_max;

  // Reset masks the grant itself so no command leaks onto the memory port.
  always_comb begin
    owner = OWN_NONE;
    if (!RESET) begin
      if (I_REQ && (!D_REQ || at_max)) begin
        owner = OWN_I;
      end else if (D_REQ) begin
        owner = OWN_D;
      end
    end
  end

  assign I_GNT = (owner == OWN_I);
  assign D_GNT = (owner == OWN_D);

  otter_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk    (CLK),
    .rst    (RESET),
    .inc    (D_GNT && I_REQ),
    .clr    (I_GNT || !I_REQ),
    .at_max (at_max)
  );

  always_comb begin
    M_RE    = 1'b0;
    M_WE    = 1'b0;
    M_ADDR  = '0;
    M_WDATA = '0;
    M_SIZE  = 2'b00;
    M_SIGN  = 1'b0;
    case (owner)
      OWN_I: begin
        M_RE   = 1'b1;
        M_ADDR = I_ADDR;
        M_SIZE = 2'b10;
      end
      OWN_D: begin
        M_RE    = !D_WE;
        M_WE    = D_WE;
        M_ADDR  = D_ADDR;
        M_WDATA = D_WDATA;
        M_SIZE  = D_SIZE;
        M_SIGN  = D_SIGN;
      end
      default: ;
    endcase
  end

  // Next state follows this cycle's grant, so every grant yields one response.
  always_comb begin
    state_d = IDLE;
    wr_d    = 1'b0;
    case (owner)
      OWN_I:   state_d = RESP_I;
      OWN_D: begin
        state_d = RESP_D;
        wr_d    = D_WE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
    end
  end

  assign I_VALID = (state_q == RESP_I);
  assign D_VALID = (state_q == RESP_D);
  assign I_RDATA = I_VALID ? M_RDATA : 32'h0;
  assign D_RDATA = (D_VALID && !wr_q) ? M_RDATA : 32'h0;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed scoreboard bench for otter_mem_arbiter (MAX_WAIT=3, ADDR_W=32).
module tb_otter_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_valid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_sign, d_gnt, d_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size;
  logic        m_re, m_we, m_sign;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_size;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ig, dg, re, we, sign;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
  } cyc_t;

  cyc_t        cyc_q[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  cyc_t        mon_e;

  always #5 clk = ~clk;

  otter_mem_arbiter #(.MAX_WAIT(3), .ADDR_W(32)) dut (
    .CLK(clk), .RESET(rst),
    .I_REQ(i_req), .I_ADDR(i_addr), .I_GNT(i_gnt), .I_VALID(i_valid), .I_RDATA(i_rdata),
    .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata), .D_SIZE(d_size),
    .D_SIGN(d_sign), .D_GNT(d_gnt), .D_VALID(d_valid), .D_RDATA(d_rdata),
    .M_RE(m_re), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata), .M_SIZE(m_size),
    .M_SIGN(m_sign), .M_RDATA(m_rdata)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h100) return 32'h00C0FFEE;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: read data one cycle after M_RE, garbage otherwise.
  always @(posedge clk) m_rdata <= m_re ? memf(m_addr) : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic eig, input logic edg, input logic keep);
    cyc_t e;
    e.ig = eig; e.dg = edg; e.re = 1'b0; e.we = 1'b0; e.sign = 1'b0;
    e.addr = 32'h0; e.wdata = 32'h0; e.size = 2'b00;
    if (eig) begin
      e.re = 1'b1; e.addr = i_addr; e.size = 2'b10;
    end else if (edg) begin
      e.re = !d_we; e.we = d_we; e.addr = d_addr; e.wdata = d_wdata;
      e.size = d_size; e.sign = d_sign;
    end
    cyc_q.push_back(e);
    if (keep && eig) iq.push_back(memf(i_addr));
    if (keep && edg) dq.push_back(d_we ? 32'h0 : memf(d_addr));
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mon_e = cyc_q.pop_front();
      chk("I_GNT",   {31'b0, i_gnt},  {31'b0, mon_e.ig});
      chk("D_GNT",   {31'b0, d_gnt},  {31'b0, mon_e.dg});
      chk("M_RE",    {31'b0, m_re},   {31'b0, mon_e.re});
      chk("M_WE",    {31'b0, m_we},   {31'b0, mon_e.we});
      chk("M_ADDR",  m_addr,          mon_e.addr);
      chk("M_WDATA", m_wdata,         mon_e.wdata);
      chk("M_SIZE",  {30'b0, m_size}, {30'b0, mon_e.size});
      chk("M_SIGN",  {31'b0, m_sign}, {31'b0, mon_e.sign});
    end
    if (i_valid) begin
      if (iq.size() == 0) chk("I_VALID_unexpected", 32'h1, 32'h0);
      else chk("I_RDATA", i_rdata, iq.pop_front());
    end else begin
      chk("I_RDATA_idle", i_rdata, 32'h0);
    end
    if (d_valid) begin
      if (dq.size() == 0) chk("D_VALID_unexpected", 32'h1, 32'h0);
      else chk("D_RDATA", d_rdata, dq.pop_front());
    end else begin
      chk("D_RDATA_idle", d_rdata, 32'h0);
    end
  end

  initial begin
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = 32'h0; d_size = 2'b10; d_sign = 1'b0;
    @(posedge clk); #1;
    // Reset holds grants and memory command low even with both requests up
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // First cycle out of reset: fetch 0x100 granted, returns 0x00C0FFEE
    rst = 1'b0; d_req = 1'b0;
    cyc(1'b1, 1'b0, 1'b1);
    i_req = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);

    // Store: M_WE=1, M_RE=0, D_RDATA=0 on response
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_size = 2'b10;
    cyc(1'b0, 1'b1, 1'b1);
    d_req = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);

    // Held contention: D,D,D,I repeating
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = 32'h0;
    for (int k = 0; k < 8; k++) cyc((k % 4) == 3, (k % 4) != 3, 1'b1);
    i_req = 1'b0; d_req = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);

    // Alternating single-cycle I and D requests
    for (int k = 0; k < 8; k++) begin
      if ((k % 2) == 0) begin
        i_req = 1'b1; i_addr = 32'h300 + 32'(4 * k); d_req = 1'b0;
        cyc(1'b1, 1'b0, 1'b1);
      end else begin
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000 + 32'(4 * k);
        cyc(1'b0, 1'b1, 1'b1);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);

    // Counter at 2, fetch drops one cycle, then D wins three more contended cycles
    i_req = 1'b1; i_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004; d_size = 2'b01; d_sign = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    i_req = 1'b0;
    cyc(1'b0, 1'b1, 1'b1);
    i_req = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    i_req = 1'b0; d_req = 1'b0; d_size = 2'b10; d_sign = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);

    // Reset in the response cycle of a D read drops that response
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008;
    cyc(1'b0, 1'b1, 1'b0);
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h500;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0; d_req = 1'b0;
    cyc(1'b1, 1'b0, 1'b1);
    i_req = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);

    chk("cyc_q_drained", 32'(cyc_q.size()), 32'h0);
    chk("iq_drained",    32'(iq.size()),    32'h0);
    chk("dq_drained",    32'(dq.size()),    32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_mem_arbiter.md
OTTER_MEM_ARBITER -- requirements
Module: otter_mem_arbiter

Interface
REQ-001 The block SHALL have a parameter MAX_WAIT, default 3, giving the number of consecutive data grants allowed while an instruction request waits.
REQ-002 The block SHALL have a parameter ADDR_W, default 32, giving the address width of all ports.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named CLK and RESET.
REQ-004 CLK  in  1  rising-edge system clock.
REQ-005 RESET  in  1  asynchronous active-high reset.
REQ-006 I_REQ  in  1 / I_ADDR  in  ADDR_W: instruction-fetch read request and byte address.
REQ-007 I_GNT  out  1 / I_VALID  out  1 / I_RDATA  out  32: fetch accepted this cycle / response valid / fetched word.
REQ-008 D_REQ  in  1 / D_WE  in  1 / D_ADDR  in  ADDR_W / D_WDATA  in  32 / D_SIZE  in  2 / D_SIGN  in  1: data-port request, write enable, address, write data, size and sign.
REQ-009 D_GNT  out  1 / D_VALID  out  1 / D_RDATA  out  32: data accepted / response valid / load data.
REQ-010 M_RE  out  1 / M_WE  out  1 / M_ADDR  out  ADDR_W / M_WDATA  out  32 / M_SIZE  out  2 / M_SIGN  out  1: single-port memory command.
REQ-011 M_RDATA  in  32: memory read data, valid one cycle after M_RE.

Function
REQ-012 The block SHALL grant at most one requester per cycle; I_GNT and D_GNT SHALL never both be high.
REQ-013 The grant SHALL be combinational from the REQ inputs in the same cycle, and M_* SHALL be a combinational mux of the granted requester's fields.
REQ-014 The M_* outputs SHALL be all zero when no requester is granted.
REQ-015 For a fetch grant, M_RE SHALL be 1, M_WE 0, M_SIZE 2'b10 and M_SIGN 0.
REQ-016 For a data grant, M_RE SHALL equal !D_WE and M_WE SHALL equal D_WE.
REQ-017 Default priority SHALL be data over instruction.
REQ-018 A 2-bit-minimum saturating counter wait_cnt SHALL increment when D is granted while I_REQ=1.
REQ-019 wait_cnt SHALL clear when I is granted or when I_REQ=0.
REQ-020 When wait_cnt==MAX_WAIT and I_REQ=1, I SHALL be granted regardless of D_REQ.
REQ-021 A registered FSM SHALL track the pending response with states IDLE, RESP_I and RESP_D.
REQ-022 The FSM SHALL transition on a grant to RESP_I or RESP_D, and to IDLE when there is no grant.
REQ-023 Transitions from any state SHALL be permitted, so back-to-back grants sustain one access per cycle.
REQ-024 In RESP_I: I_VALID SHALL be 1 and I_RDATA SHALL equal M_RDATA.
REQ-025 In RESP_D: D_VALID SHALL be 1, and D_RDATA SHALL equal M_RDATA for a read and 0 for a write.
REQ-026 A write SHALL also produce D_VALID exactly one cycle after its grant.
REQ-027 Every granted request SHALL produce exactly one VALID pulse exactly one cycle after its grant.
REQ-028 A requester that keeps REQ high SHALL be re-arbitrated every cycle.
REQ-029 Requesters SHALL hold their fields stable only during the grant cycle.
REQ-030 I_RDATA SHALL be 0 when I_VALID=0, and D_RDATA SHALL be 0 when D_VALID=0.

Reset
REQ-031 While RESET=1: the FSM SHALL be IDLE, wait_cnt 0, I_VALID and D_VALID 0, I_GNT and D_GNT forced 0, and M_RE and M_WE 0.
REQ-032 An access granted in the cycle reset asserts SHALL produce no VALID; the outstanding response is dropped.
REQ-033 The first grant after reset SHALL be possible in the first cycle with RESET=0.

Structure
REQ-034 Package otter_arb_pkg SHALL hold the state enum (IDLE, RESP_I, RESP_D), the owner enum (OWN_NONE, OWN_I, OWN_D) and the MAX_WAIT default constant.
REQ-035 Sub-module otter_arb_starve_ctr SHALL implement the saturating wait_cnt: inputs inc and clr, output at_max.
REQ-036 All other logic SHALL reside in otter_mem_arbiter.

Verification
REQ-037 The bench SHALL cover: I_REQ=1, I_ADDR=0x100, D_REQ=0 -> I_GNT=1 and M_ADDR=0x100 in the same cycle; next cycle I_VALID=1 and I_RDATA=M_RDATA=0x00C0FFEE.
REQ-038 The bench SHALL cover: I_REQ=1 and D_REQ=1 (D_WE=0, D_ADDR=0x2000) both held high with MAX_WAIT=3 -> D granted 3 cycles, I granted on cycle 4, then D again; the pattern repeats.
REQ-039 The bench SHALL cover: D_REQ=1, D_WE=1, D_WDATA=0xDEADBEEF, D_SIZE=2'b10 -> M_WE=1, M_RE=0, M_WDATA=0xDEADBEEF; next cycle D_VALID=1 and D_RDATA=0.
REQ-040 The bench SHALL cover alternating single-cycle I and D requests for 8 cycles -> 8 grants, 8 VALID pulses, each routed to the correct port with 1-cycle latency.
REQ-041 The bench SHALL cover RESET asserted in the cycle after a D read grant -> D_VALID stays 0 and all outputs are 0; after release, I_REQ=1 is granted in the first cycle.
REQ-042 The bench SHALL cover: I_REQ dropped for 1 cycle while wait_cnt=2 -> wait_cnt clears, and D wins the next 3 contended cycles.
